mem_port_arbiter: RTL

Sequencing controller and two-port arbiter for the single-port zero-delay RAM of the RISC-V32I core. It shares the RAM's one address/write port between the instruction-fetch requester and the load/store requester using round-robin arbitration. The RAM stores whole 32-bit words only, so this block performs byte and halfword extraction, sign/zero extension and read-modify-write for sub-word stores. It sits between the core's fetch/memory stages and the RAM.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter and sequencer for a word-only single-port RAM
module mem_port_arbiter #(
  parameter int addrW = 32,
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [addrW-1:0] if_addr,
  output logic             if_ack,
  output logic             if_err,
  output logic [dataW-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [1:0]       d_size,
  input  logic             d_unsigned,
  input  logic [addrW-1:0] d_addr,
  input  logic [dataW-1:0] d_wdata,
  output logic             d_ack,
  output logic             d_err,
  output logic [dataW-1:0] d_rdata,
  output logic [addrW-1:0] ram_addr,
  output logic [dataW-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [dataW-1:0] ram_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        last_grant;   // 0 = fetch, 1 = data
  logic        g_data;
  logic        g_we;
  logic [1:0]  g_size;
  logic        g_uns;
  logic [1:0]  g_off;
  logic [15:0] g_wdata;

  logic             pick_data;
  logic             req_err;
  logic [addrW-1:0] req_addr;

  // Winner selection and alignment check for the requester sampled in IDLE.
  always_comb begin
    pick_data = d_req && (!if_req || !last_grant);
    req_addr  = pick_data ? d_addr : if_addr;
    req_err   = 1'b0;
    if (!pick_data) begin
      req_err = (if_addr[1:0] != 2'b00);
    end else begin
      case (d_size)
        2'b00:   req_err = 1'b0;
        2'b01:   req_err = d_addr[0];
        2'b10:   req_err = (d_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end
  end

  function automatic logic [dataW-1:0] load_extract(input logic [dataW-1:0] w,
                                                    input logic [1:0] off,
                                                    input logic [1:0] sz,
                                                    input logic uns);
    logic [dataW-1:0] sh;
    logic [7:0]       b;
    logic [15:0]      h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [dataW-1:0] store_merge(input logic [dataW-1:0] w,
                                                   input logic [1:0] off,
                                                   input logic [1:0] sz,
                                                   input logic [15:0] d);
    logic [dataW-1:0] m;
    m = w;
    if (sz == 2'b00) m[{off, 3'b000} +: 8] = d[7:0];
    else             m[{off[1], 4'b0000} +: 16] = d;
    return m;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      g_data     <= 1'b0;
      g_we       <= 1'b0;
      g_size     <= 2'b00;
      g_uns      <= 1'b0;
      g_off      <= 2'b00;
      g_wdata    <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            g_data  <= pick_data;
            g_we    <= pick_data && d_we;
            g_size  <= pick_data ? d_size : 2'b10;
            g_uns   <= d_unsigned;
            g_off   <= req_addr[1:0];
            g_wdata <= d_wdata[15:0];
            if (req_err) begin
              state  <= RESP;
              if_ack <= !pick_data;
              if_err <= !pick_data;
              d_ack  <= pick_data;
              d_err  <= pick_data;
            end else if (pick_data && d_we && d_size == 2'b10) begin
              state     <= WRITE;
              ram_addr  <= {req_addr[addrW-1:2], 2'b00};
              ram_wdata <= d_wdata;
              ram_we    <= 1'b1;
            end else begin
              state    <= READ;
              ram_addr <= {req_addr[addrW-1:2], 2'b00};
            end
          end
        end
        READ: begin
          if (g_we) begin
            // Sub-word store: the old word is on ram_rdata now, write back the merge.
            state     <= WRITE;
            ram_wdata <= store_merge(ram_rdata, g_off, g_size, g_wdata);
            ram_we    <= 1'b1;
          end else begin
            state    <= RESP;
            ram_addr <= '0;
            if (g_data) begin
              d_ack   <= 1'b1;
              d_rdata <= load_extract(ram_rdata, g_off, g_size, g_uns);
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end
        end
        WRITE: begin
          state     <= RESP;
          ram_we    <= 1'b0;
          ram_wdata <= '0;
          ram_addr  <= '0;
          d_ack     <= 1'b1;
          d_rdata   <= '0;
        end
        default: begin
          state      <= IDLE;
          last_grant <= g_data;
          if_ack     <= 1'b0;
          if_err     <= 1'b0;
          if_rdata   <= '0;
          d_ack      <= 1'b0;
          d_err      <= 1'b0;
          d_rdata    <= '0;
        end
      endcase
    end
  end

endmodule
